// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encodings and the
// step-counter width helper.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_ADD  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  // Wide enough to hold the step count N = width/step itself, not just N-1.
  function automatic int cnt_width(input int width, input int step);
    return $clog2(width / step + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; the requester drives operands
// and start, the adder returns status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder, chained STEP deep inside the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: STEP bits per clock, LSB first, through a
// full-adder chain; the result is published in one shot at completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int              N    = WIDTH / STEP;
  localparam int              CW   = cnt_width(WIDTH, STEP);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, acc_reg, sum_reg;
  logic               carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]      cnt_reg;

  logic [STEP:0]      chain_c;
  logic [STEP-1:0]    chain_s;
  logic [WIDTH-1:0]   acc_shift;
  logic               last_step;

  assign chain_c[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_chain
      fa_cell u_fa (
        .a  (a_reg[gi]),
        .b  (b_reg[gi]),
        .c  (chain_c[gi]),
        .s  (chain_s[gi]),
        .co (chain_c[gi+1])
      );
    end

    // New bits enter at the top so that after N steps the LSB lands at bit 0.
    if (STEP < WIDTH) begin : g_acc_shift
      assign acc_shift = {chain_s, acc_reg[WIDTH-1:STEP]};
    end else begin : g_acc_whole
      assign acc_shift = chain_s;
    end
  endgenerate

  assign last_step = (state_reg == S_ADD) && (cnt_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_ADD;
      S_ADD:   if (cnt_reg == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + ~borrow_in.
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.cin ^ bus.sub;
            acc_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        S_ADD: begin
          a_reg     <= a_reg >> STEP;
          b_reg     <= b_reg >> STEP;
          carry_reg <= chain_c[STEP];
          acc_reg   <= acc_shift;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_step) begin
            sum_reg  <= acc_shift;
            cout_reg <= chain_c[STEP];
            ovf_reg  <= chain_c[STEP] ^ chain_c[STEP-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == S_ADD);
  assign bus.done = (state_reg == S_DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit STEP=1 and an 8-bit STEP=4
// instance share clock and reset; results are checked as done pulses arrive.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();

  serial_adder #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_adder #(.WIDTH(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t q1[$];
  res_t q4[$];
  res_t held1 = '0;
  res_t held4 = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 9'(cin ^ sub);
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return r;
  endfunction

  // Result monitors: pop on done, otherwise the published result must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.done) begin
        if (q1.size() == 0) check_eq("spurious_done1", 1, 0);
        else begin
          held1 = q1.pop_front();
          check_eq("result1", {bus1.sum, bus1.cout, bus1.ovf}, held1);
        end
      end else
        check_eq("hold1", {bus1.sum, bus1.cout, bus1.ovf}, held1);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus4.done) begin
        if (q4.size() == 0) check_eq("spurious_done4", 1, 0);
        else begin
          held4 = q4.pop_front();
          check_eq("result4", {bus4.sum, bus4.cout, bus4.ovf}, held4);
        end
      end else
        check_eq("hold4", {bus4.sum, bus4.cout, bus4.ovf}, held4);
    end
  end

  task automatic drive(input bit s4, input logic st, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic su);
    if (s4) begin
      bus4.start = st; bus4.a = a; bus4.b = b; bus4.cin = ci; bus4.sub = su;
    end else begin
      bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = ci; bus1.sub = su;
    end
  endtask

  // One operation: checks latency, busy length and that operands are captured.
  task automatic run_op(input bit s4, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic su, input bit poke, input string tag);
    int n;
    int lat;
    int busyc;
    bit got;
    n = s4 ? 2 : 8;
    lat = 0; busyc = 0; got = 0;
    @(negedge clk);
    if (s4) q4.push_back(model(a, b, ci, su));
    else    q1.push_back(model(a, b, ci, su));
    drive(s4, 1'b1, a, b, ci, su);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) drive(s4, 1'b0, ~a, ~b, ~ci, ~su);
      if (poke && i == 2) drive(s4, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1);
      if (poke && i == 3) drive(s4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      if (s4 ? bus4.busy : bus1.busy) busyc++;
      if (s4 ? bus4.done : bus1.done) got = 1;
    end
    check_eq({tag, "_done_seen"}, 64'(got), 1);
    check_eq({tag, "_latency"}, lat, n + 1);
    check_eq({tag, "_busy_cycles"}, busyc, n);
    $display("op %s: a=%02h b=%02h cin=%0b sub=%0b latency=%0d", tag, a, b, ci, su, lat);
  endtask

  initial begin
    int k;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check_eq("reset_state1", {bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf}, 0);
    check_eq("reset_state4", {bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "ff_plus_01");
    check_eq("ff_plus_01_lit", {bus1.sum, bus1.cout, bus1.ovf}, {8'h00, 1'b1, 1'b0});
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "7f_plus_01");
    check_eq("7f_plus_01_lit", {bus1.sum, bus1.cout, bus1.ovf}, {8'h80, 1'b0, 1'b1});
    run_op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, "05_minus_07");
    check_eq("05_minus_07_lit", {bus1.sum, bus1.cout, bus1.ovf}, {8'hFE, 1'b0, 1'b0});
    run_op(1'b1, 8'h3C, 8'h4A, 1'b1, 1'b0, 1'b0, "step4_3c_4a");
    check_eq("step4_lit", {bus4.sum, bus4.cout, bus4.ovf}, {8'h87, 1'b0, 1'b1});

    run_op(1'b0, 8'h21, 8'h13, 1'b1, 1'b0, 1'b1, "start_while_busy");
    check_eq("start_while_busy_lit", bus1.sum, 8'h35);

    for (int i = 0; i < 6; i++)
      run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand1");
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand4");

    // start held high: two operations, period N+2
    @(negedge clk);
    q1.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    q1.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    k = 0;
    while (!bus1.done && k < 40) begin @(negedge clk); k++; end
    check_eq("b2b_first_latency", k, 9);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus1.done && k < 40);
    check_eq("b2b_period", k, 10);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    $display("op b2b: period=%0d", k);

    // Leave a non-zero result so the reset clearing is observable.
    run_op(1'b0, 8'h90, 8'h90, 1'b0, 1'b0, 1'b0, "90_plus_90");
    check_eq("90_plus_90_lit", {bus1.sum, bus1.cout, bus1.ovf}, {8'h20, 1'b1, 1'b1});

    // Reset in the third ADD cycle
    @(negedge clk);
    q1.push_back(model(8'hAA, 8'h11, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 8'hAA, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("busy_before_rst", bus1.busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_clear", {bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf}, 0);
    q1.delete();
    held1 = '0;
    held4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("op reset_abort: outputs cleared");
    repeat (12) @(negedge clk);
    run_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, "after_rst");
    check_eq("after_rst_lit", {bus1.sum, bus1.cout, bus1.ovf}, {8'h30, 1'b0, 1'b0});

    repeat (3) @(negedge clk);
    check_eq("q1_drained", q1.size(), 0);
    check_eq("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 Parameter STEP, default 1, bits processed per clock; WIDTH mod STEP shall equal 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 cin  input  1  carry-in (add) or borrow-in (subtract), captured when start is accepted.
REQ-009 sub  input  1  mode: 0 = add, 1 = subtract, captured when start is accepted.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when the result registers update.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 FSM states IDLE, ADD, DONE; IDLE->ADD when start=1; ADD->DONE after N = WIDTH/STEP steps; DONE->IDLE unconditionally.
REQ-016 Accepting start latches a, b, sub, and effective carry = cin (add) or ~cin (subtract); in subtract mode b is bit-inverted, giving a + b + cin or a - b - cin.
REQ-017 Each ADD cycle consumes the next STEP bits LSB-first through a STEP-deep full-adder chain; the carry register feeds the next step.
REQ-018 busy shall be high for exactly N cycles, starting the cycle after the start edge; done shall be high for exactly one cycle, immediately after busy falls (start-to-done latency N+1 cycles).
REQ-019 sum, cout and ovf shall update only on the edge that raises done and shall hold that value until the next done; partial results are never visible.
REQ-020 start shall be ignored in ADD and DONE; captured operands shall not change mid-operation.
REQ-021 start held high continuously shall yield back-to-back operations, each re-accepted in IDLE (period N+2 cycles).
REQ-022 Wrap-around: sum is the low WIDTH bits of the full result; the carry shall be reported only via cout.

Reset
REQ-023 rst=1 forces, without waiting for clk, state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clears the internal operand, carry and step-counter registers.
REQ-024 rst during ADD aborts the operation; no done pulse follows, and the first start after rst release behaves as from power-up.

Structure
REQ-025 Shared package serial_adder_pkg shall hold the FSM state encodings and the step-counter width function ceil(log2(WIDTH/STEP+1)).
REQ-026 One sub-module, fa_cell (1-bit full adder: sum = a^b^c, carry = majority), instantiated STEP times in a generate chain.

Verification
REQ-027 WIDTH=8, STEP=1: a=8'hFF, b=8'h01, cin=0, sub=0, start -> done 9 cycles after start, sum=8'h00, cout=1, ovf=0.
REQ-028 WIDTH=8, STEP=1: a=8'h7F, b=8'h01, add -> sum=8'h80, cout=0, ovf=1.
REQ-029 WIDTH=8, STEP=1: a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0, ovf=0.
REQ-030 WIDTH=8, STEP=4: a=8'h3C, b=8'h4A, cin=1, add -> done 3 cycles after start, sum=8'h87, cout=0, ovf=1.
REQ-031 Pulse start with new operands while busy=1 -> ignored; result matches the first operands; only one done pulse.
REQ-032 Assert rst during the third ADD cycle -> busy, done, sum, cout, ovf all 0 immediately; no done pulse; the next start (a=8'h10, b=8'h20) gives sum=8'h30 after normal latency.
